// File: rtl/alu_pkg.sv
// Shared types for the sequential execute-stage ALU.
// Opcodes, flag bit positions and FSM states.
package alu_pkg;

   typedef enum logic [2:0] {
      ADD = 3'b000,
      SUB = 3'b001,
      AND = 3'b010,
      OR  = 3'b011,
      MOV = 3'b100,
      MUL = 3'b101,
      MOD = 3'b110,
      RSV = 3'b111
   } opcode_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      MUL_RUN = 2'b01,
      MOD_RUN = 2'b10
   } state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Bit-serial datapath for MUL (shift-add) and MOD (restoring division).
// One operand bit per cycle, MSB first; done flags the final iteration.
module alu_iter_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         is_mod,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         done,
   output logic [N-1:0] res,
   output logic         hi_nz
);

   localparam int CW = $clog2(N);

   logic           busy;
   logic           mode;
   logic [N-1:0]   a_q;
   logic [N-1:0]   b_q;
   logic [2*N-1:0] acc;
   logic [N-1:0]   rem;
   logic [CW-1:0]  cnt;

   logic [2*N-1:0] acc_next;
   logic [N:0]     trial;
   logic [N:0]     diff;
   logic [N-1:0]   rem_next;

   // Results are taken from the next-state values so the last
   // iteration and the output register load share one edge.
   always_comb begin
      acc_next = (acc << 1) + (b_q[cnt] ? {{N{1'b0}}, a_q} : '0);
      trial    = {rem, a_q[cnt]};
      diff     = trial - {1'b0, b_q};
      rem_next = diff[N] ? trial[N-1:0] : diff[N-1:0];
   end

   assign done  = busy && (cnt == '0);
   assign res   = mode ? rem_next : acc_next[N-1:0];
   assign hi_nz = |acc_next[2*N-1:N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         mode <= 1'b0;
         a_q  <= '0;
         b_q  <= '0;
         acc  <= '0;
         rem  <= '0;
         cnt  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         mode <= is_mod;
         a_q  <= a;
         b_q  <= b;
         acc  <= '0;
         rem  <= '0;
         cnt  <= CW'(N - 1);
      end else if (busy) begin
         acc <= acc_next;
         rem <= rem_next;
         if (cnt == '0) busy <= 1'b0;
         else           cnt  <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: registered result, valid/ready request handshake,
// single-cycle logic ops plus iterative MUL and MOD.
module alu_seq
   import alu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [2:0]   opcode_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic         valid_o,
   output logic [N-1:0] result_o,
   output logic [3:0]   ALUFlags
);

   state_e        state;
   state_e        state_d;
   opcode_e       op;
   logic [N:0]    sum;
   logic [N:0]    dif;
   logic          load;
   logic          start;
   logic          is_mod;
   logic          cf;
   logic          vf;
   logic [N-1:0]  res_d;
   logic [3:0]    flags_d;
   logic          done;
   logic [N-1:0]  iter_res;
   logic          iter_hi;

   assign op      = opcode_e'(opcode_i);
   assign sum     = {1'b0, a_i} + {1'b0, b_i};
   assign dif     = {1'b0, a_i} - {1'b0, b_i};
   assign ready_o = (state == IDLE);

   alu_iter_unit #(.N(N)) u_iter (
      .clk    (clk_i),
      .rst_n  (rst_ni),
      .start  (start),
      .is_mod (is_mod),
      .a      (a_i),
      .b      (b_i),
      .done   (done),
      .res    (iter_res),
      .hi_nz  (iter_hi)
   );

   always_comb begin
      state_d = state;
      load    = 1'b0;
      start   = 1'b0;
      is_mod  = 1'b0;
      res_d   = '0;
      cf      = 1'b0;
      vf      = 1'b0;
      unique case (state)
         IDLE: if (valid_i) begin
            unique case (op)
               ADD: begin
                  load  = 1'b1;
                  res_d = sum[N-1:0];
                  cf    = sum[N];
                  vf    = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
               end
               SUB: begin
                  load  = 1'b1;
                  res_d = dif[N-1:0];
                  cf    = ~dif[N];
                  vf    = (a_i[N-1] != b_i[N-1]) && (dif[N-1] != a_i[N-1]);
               end
               AND: begin load = 1'b1; res_d = a_i & b_i; end
               OR:  begin load = 1'b1; res_d = a_i | b_i; end
               MOV: begin load = 1'b1; res_d = b_i; end
               MUL: begin start = 1'b1; state_d = MUL_RUN; end
               MOD: begin
                  // Divide-by-zero short-circuits with an error flag.
                  if (b_i == '0) begin
                     load  = 1'b1;
                     res_d = a_i;
                     vf    = 1'b1;
                  end else begin
                     start   = 1'b1;
                     is_mod  = 1'b1;
                     state_d = MOD_RUN;
                  end
               end
               RSV: begin load = 1'b1; vf = 1'b1; end
               default: ;
            endcase
         end
         MUL_RUN: if (done) begin
            load    = 1'b1;
            res_d   = iter_res;
            cf      = iter_hi;
            state_d = IDLE;
         end
         MOD_RUN: if (done) begin
            load    = 1'b1;
            res_d   = iter_res;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      flags_d         = '0;
      flags_d[FLAG_N] = res_d[N-1];
      flags_d[FLAG_Z] = (res_d == '0);
      flags_d[FLAG_C] = cf;
      flags_d[FLAG_V] = vf;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         valid_o  <= 1'b0;
         result_o <= '0;
         ALUFlags <= '0;
      end else begin
         state   <= state_d;
         valid_o <= load;
         if (load) begin
            result_o <= res_d;
            ALUFlags <= flags_d;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (N = 32).
// Hand-computed vectors, immediate assertions at each check point.
module tb_alu_seq;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [2:0]  opcode_i = 3'd0;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        valid_o;
   logic [31:0] result_o;
   logic [3:0]  ALUFlags;

   int n_chk = 0;
   int n_fail = 0;

   alu_seq #(.N(32)) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .opcode_i (opcode_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .valid_o  (valid_o),
      .result_o (result_o),
      .ALUFlags (ALUFlags)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Issue one request; return outputs at the valid_o cycle, the number
   // of edges after the accept edge, and the count of ready_o-low cycles.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res,
                         output logic [3:0] fl, output int edges,
                         output int low);
      int w;
      w = 0;
      @(negedge clk_i);
      while (!ready_o && w < 100) begin
         @(negedge clk_i);
         w++;
      end
      opcode_i = op;
      a_i      = a;
      b_i      = b;
      valid_i  = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i  = 1'b0;
      opcode_i = 3'd2;
      a_i      = 32'hdead_beef;
      b_i      = 32'h0000_0013;
      edges = 0;
      low   = 0;
      @(negedge clk_i);
      while (!valid_o && edges < 100) begin
         if (!ready_o) low++;
         @(posedge clk_i);
         edges++;
         @(negedge clk_i);
      end
      res = result_o;
      fl  = ALUFlags;
   endtask

   logic [31:0] res;
   logic [3:0]  fl;
   int          edges;
   int          low;
   int          seen;

   initial begin
      #12;
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_ready", {31'd0, ready_o}, 32'd1);
      check("rst_result", result_o, 32'd0);
      check("rst_flags", {28'd0, ALUFlags}, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      run_op(3'b000, 32'd1, 32'd10, res, fl, edges, low);
      check("add_res", res, 32'd11);
      check("add_flags", {28'd0, fl}, 32'h0);
      check("add_lat", edges, 32'd0);
      @(negedge clk_i);
      check("add_pulse", {31'd0, valid_o}, 32'd0);

      run_op(3'b001, 32'd10, 32'd10, res, fl, edges, low);
      check("sub_eq_res", res, 32'd0);
      check("sub_eq_flags", {28'd0, fl}, 32'h6);

      run_op(3'b001, 32'd1, 32'd10, res, fl, edges, low);
      check("sub_neg_res", res, 32'hffff_fff7);
      check("sub_neg_flags", {28'd0, fl}, 32'h8);

      @(negedge clk_i);
      opcode_i = 3'b010; a_i = 32'd10; b_i = 32'd10; valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      opcode_i = 3'b011; a_i = 32'd11; b_i = 32'd10;
      @(negedge clk_i);
      check("and_valid", {31'd0, valid_o}, 32'd1);
      check("and_res", result_o, 32'd10);
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      @(negedge clk_i);
      check("or_valid", {31'd0, valid_o}, 32'd1);
      check("or_res", result_o, 32'd11);
      @(negedge clk_i);
      check("or_pulse", {31'd0, valid_o}, 32'd0);

      run_op(3'b100, 32'd99, 32'd11, res, fl, edges, low);
      check("mov_res", res, 32'd11);
      check("mov_flags", {28'd0, fl}, 32'h0);

      run_op(3'b101, 32'h0001_0000, 32'h0001_0000, res, fl, edges, low);
      check("mul_big_res", res, 32'd0);
      check("mul_big_flags", {28'd0, fl}, 32'h6);
      check("mul_big_lat", edges, 32'd32);
      check("mul_big_busy", low, 32'd32);
      check("mul_big_ready", {31'd0, ready_o}, 32'd1);
      @(negedge clk_i);
      check("mul_big_pulse", {31'd0, valid_o}, 32'd0);

      run_op(3'b101, 32'd7, 32'd6, res, fl, edges, low);
      check("mul_res", res, 32'd42);
      check("mul_flags", {28'd0, fl}, 32'h0);

      run_op(3'b110, 32'd100, 32'd7, res, fl, edges, low);
      check("mod_res", res, 32'd2);
      check("mod_flags", {28'd0, fl}, 32'h0);
      check("mod_lat", edges, 32'd32);

      run_op(3'b110, 32'd5, 32'd0, res, fl, edges, low);
      check("mod0_res", res, 32'd5);
      check("mod0_flags", {28'd0, fl}, 32'h1);
      check("mod0_lat", edges, 32'd0);

      run_op(3'b111, 32'd3, 32'd4, res, fl, edges, low);
      check("rsv_res", res, 32'd0);
      check("rsv_flags", {28'd0, fl}, 32'h5);

      @(negedge clk_i);
      opcode_i = 3'b101; a_i = 32'd9; b_i = 32'd9; valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      repeat (10) @(negedge clk_i);
      rst_ni = 1'b0;
      #2;
      check("mid_rst_ready", {31'd0, ready_o}, 32'd1);
      check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
      check("mid_rst_result", result_o, 32'd0);
      check("mid_rst_flags", {28'd0, ALUFlags}, 32'd0);
      #1;
      rst_ni = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk_i);
         if (valid_o) seen++;
      end
      check("mid_rst_no_valid", seen, 32'd0);

      run_op(3'b000, 32'h7fff_ffff, 32'd1, res, fl, edges, low);
      check("post_rst_add_res", res, 32'h8000_0000);
      check("post_rst_add_flags", {28'd0, fl}, 32'h9);

      run_op(3'b000, 32'hffff_ffff, 32'd1, res, fl, edges, low);
      check("add_carry_res", res, 32'd0);
      check("add_carry_flags", {28'd0, fl}, 32'h6);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, want finish");
      $fatal(1, "timeout");
   end

endmodule
